// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N bus masters and the round-robin arbiter.
// The lock signal exists only when ARB_LOCK_EN is defined.
interface rr_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
`ifdef ARB_LOCK_EN
  logic             lock;
`endif

  modport master (
    output req,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  req,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output grant,
    output grant_valid,
    output grant_idx
  );
endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: registered one-hot grant, tenure capped at MAX_HOLD
// cycles while others wait. Define ARB_LOCK_EN to add a lock input that extends tenure.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         res_n,
  rr_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(N);
  // Sized so that MAX_HOLD=1 still yields a legal 1-bit counter.
  localparam int HC_W  = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [N-1:0]     others;
  logic [IDX_W:0]   pick_res;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             holder_req;
  logic             at_limit;
  logic             lock_hold;
  logic             new_grant;

  // First set bit of vec searching start, start+1, ... with wrap; returns {found, idx}.
  function automatic logic [IDX_W:0] pick(input logic [N-1:0] vec,
                                          input logic [IDX_W-1:0] start);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && vec[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

  // The holder never competes against itself; in IDLE grant_q is zero so this is just req.
  assign others    = bus.req & ~grant_q;
  assign pick_res  = pick(others, ptr_q);
  assign win_found = pick_res[IDX_W];
  assign win_idx   = pick_res[IDX_W-1:0];

  assign holder_req = bus.req[grant_idx_q];
  assign at_limit   = (hold_cnt_q == HC_W'(MAX_HOLD - 1));
`ifdef ARB_LOCK_EN
  assign lock_hold  = bus.lock;
`else
  assign lock_hold  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    new_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) new_grant = 1'b1;
      end
      GRANT: begin
        if (!holder_req) begin
          if (win_found) begin
            new_grant = 1'b1;
          end else begin
            state_d     = IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
          end
        end else if (!at_limit) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end else if (win_found && !lock_hold) begin
          new_grant = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (new_grant) begin
      state_d     = GRANT;
      grant_d     = N'(1) << win_idx;
      grant_idx_d = win_idx;
      ptr_d       = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + IDX_W'(1);
      hold_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant_idx   = grant_idx_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: instance A (N=4, MAX_HOLD=4) and B (N=4, MAX_HOLD=1).
// Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter_if #(.N(4)) bus_a ();
  rr_arbiter_if #(.N(4)) bus_b ();

  rr_arbiter #(.N(4), .MAX_HOLD(4)) u_dut_a (.clk(clk), .res_n(res_n), .bus(bus_a));
  rr_arbiter #(.N(4), .MAX_HOLD(1)) u_dut_b (.clk(clk), .res_n(res_n), .bus(bus_b));

  typedef struct {
    bit         sel;
    logic [3:0] g;
    logic       v;
    logic [1:0] idx;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  task automatic check(input string name, input logic [3:0] g, input logic v, input logic [1:0] idx,
                       input logic [3:0] eg, input logic ev, input logic [1:0] eidx);
    checks++;
    if (g !== eg || v !== ev || idx !== eidx) begin
      errors++;
      $display("FAIL %s: got grant=%b valid=%b idx=%0d, expected grant=%b valid=%b idx=%0d",
               name, g, v, idx, eg, ev, eidx);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
  task automatic step(input bit sel, input logic [3:0] r, input logic lk, input logic [3:0] eg,
                      input string name);
    exp_t e;
    @(negedge clk);
    if (sel) bus_b.req = r;
    else     bus_a.req = r;
`ifdef ARB_LOCK_EN
    bus_a.lock = lk;
`endif
    e.sel  = sel;
    e.g    = eg;
    e.v    = (eg != 4'b0000);
    e.idx  = (eg == 4'b0010) ? 2'd1 : (eg == 4'b0100) ? 2'd2 : (eg == 4'b1000) ? 2'd3 : 2'd0;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compares whenever an expectation is pending, one per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel) check(e.name, bus_b.grant, bus_b.grant_valid, bus_b.grant_idx, e.g, e.v, e.idx);
        else       check(e.name, bus_a.grant, bus_a.grant_valid, bus_a.grant_idx, e.g, e.v, e.idx);
      end
    end
  end

  initial begin
    bus_a.req = 4'b1111;
    bus_b.req = 4'b1111;
`ifdef ARB_LOCK_EN
    bus_a.lock = 1'b0;
    bus_b.lock = 1'b0;
`endif
    // Reset held with all requesters active: nothing may be granted.
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", bus_a.grant, bus_a.grant_valid, bus_a.grant_idx, 4'b0000, 1'b0, 2'd0);
    check("reset_b", bus_b.grant, bus_b.grant_valid, bus_b.grant_idx, 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;
    res_n     = 1'b1;

    step(0, 4'b0000, 1'b0, 4'b0000, "idle_after_reset");
    step(0, 4'b0100, 1'b0, 4'b0100, "single_first");
    for (int k = 0; k < 10; k++) step(0, 4'b0100, 1'b0, 4'b0100, "single_hold");

    // Asynchronous reset mid-grant clears outputs before the next edge.
    @(posedge clk);
    #2;
    res_n = 1'b0;
    #1;
    check("async_reset", bus_a.grant, bus_a.grant_valid, bus_a.grant_idx, 4'b0000, 1'b0, 2'd0);
    bus_a.req = 4'b0000;
    @(negedge clk);
    res_n = 1'b1;

    // Full load from ptr=0: four cycles per requester, then wrap.
    for (int k = 0; k < 17; k++)
      step(0, 4'b1111, 1'b0, 4'b0001 << ((k / 4) % 4), "full_load");

    step(0, 4'b0010, 1'b0, 4'b0010, "release_to_1");
    step(0, 4'b1001, 1'b0, 4'b1000, "early_release_3");
    step(0, 4'b0001, 1'b0, 4'b0001, "release_to_0");
    step(0, 4'b0000, 1'b0, 4'b0000, "release_idle");

    // MAX_HOLD=1 rotates every cycle between two requesters.
    for (int k = 0; k < 6; k++)
      step(1, 4'b0101, 1'b0, (k % 2 == 0) ? 4'b0001 : 4'b0100, "maxhold1_alt");
    step(1, 4'b0000, 1'b0, 4'b0000, "maxhold1_idle");

`ifdef ARB_LOCK_EN
    step(0, 4'b0001, 1'b0, 4'b0001, "lock_setup");
    for (int k = 0; k < 10; k++) step(0, 4'b0011, 1'b1, 4'b0001, "lock_hold");
    step(0, 4'b0011, 1'b0, 4'b0010, "lock_drop_rotate");
`else
    // Same pattern without lock: tenure is capped at four cycles.
    step(0, 4'b0001, 1'b0, 4'b0001, "cap_setup");
    for (int k = 0; k < 3; k++) step(0, 4'b0011, 1'b0, 4'b0001, "cap_hold");
    step(0, 4'b0011, 1'b0, 4'b0010, "cap_rotate");
`endif
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (!stim_done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: stim_done=%0d pending=%0d, expected stim_done=1 pending=0",
               stim_done, exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
